mult_arb_2p: RTL
================

MULT_ARB_2P -- requirements
Module: mult_arb_2p

Interface
REQ-001 SHALL have parameter PRIO_INIT, default 0, meaning the port (0 or 1) favoured on the first arbitration after reset.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports P0_Valid / P1_Valid, input, 1 each, request valid.
REQ-005 SHALL have ports P0_Ready / P1_Ready, output, 1 each, request accepted this cycle.
REQ-006 SHALL have ports P0_InA / P1_InA, input, 4 each, multiplicand.
REQ-007 SHALL have ports P0_InB / P1_InB, input, 4 each, multiplier.
REQ-008 SHALL have ports P0_RespValid / P1_RespValid, output, 1 each, product valid.
REQ-009 SHALL have ports P0_RespReady / P1_RespReady, input, 1 each, requester takes product.
REQ-010 SHALL have ports P0_Out / P1_Out, output, 8 each, unsigned product.
REQ-011 SHALL have port Busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL share one arr_multiplier_4b instance between both ports, with its Reset pin tied to 1 and its inputs driven only from internal operand registers.
REQ-013 SHALL implement FSM states IDLE, CALC and RESP; the encoding is free.
REQ-014 In IDLE, Px_Ready SHALL be combinationally high only for the granted port, and only when that port's Px_Valid is high.
REQ-015 If exactly one Px_Valid is high in IDLE, that port SHALL be granted.
REQ-016 If both Px_Valid are high in IDLE, the port not served last SHALL be granted (round-robin); the first such tie after reset SHALL go to PRIO_INIT.
REQ-017 On acceptance, InA/InB and the grant index SHALL be registered, and the FSM SHALL move IDLE->CALC.
REQ-018 In CALC, the multiplier output SHALL be registered into the result register, and the FSM SHALL move CALC->RESP.
REQ-019 In RESP, only the granted port's Px_RespValid SHALL be high, and the result SHALL be driven on that port's Px_Out.
REQ-020 Px_Out SHALL be 0 for the port that is not responding.
REQ-021 In RESP, Px_Out SHALL stay stable until Px_RespReady is high; that handshake SHALL update the last-served pointer and move RESP->IDLE.
REQ-022 Px_RespValid SHALL rise exactly 2 cycles after the accepting edge.
REQ-023 Peak throughput SHALL be one operation per 3 cycles; no request SHALL be accepted outside IDLE.
REQ-024 Px_RespReady SHALL be ignored while Px_RespValid is low.
REQ-025 Px_Valid dropping in CALC/RESP SHALL have no effect on the operation in flight.
REQ-026 Products SHALL be full-width unsigned (max 15x15=225), with no truncation.

Reset
REQ-027 While Reset is high at a clock edge, the FSM SHALL go to IDLE and all Ready, RespValid, Out, Busy outputs and operand/result registers SHALL clear to 0.
REQ-028 Reset SHALL set the last-served pointer so the next tie is granted to PRIO_INIT.
REQ-029 Reset asserted in CALC or RESP SHALL abort the operation; no response SHALL be issued for it.

Configuration
REQ-030 When MULT_ARB_CNT_EN is defined, the block SHALL add outputs P0_GrantCnt / P1_GrantCnt (8 bits each).
REQ-031 With MULT_ARB_CNT_EN defined, each counter SHALL increment on its port's request acceptance, saturate at 255, and clear on Reset.
REQ-032 Without MULT_ARB_CNT_EN, the counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 P0 only, InA=9, InB=7, RespReady=1 -> P0_Ready high in cycle 0; P0_RespValid high in cycle 2 with P0_Out=63; P1 outputs stay 0.
REQ-034 P1 only, InA=15, InB=15 -> P1_Out=225; InA=0, InB=13 -> P1_Out=0.
REQ-035 Both valid after reset, PRIO_INIT=0, operands 3x4 and 5x6 held -> P0 served first (Out=12), then P1 (Out=30), then P0 again.
REQ-036 P0_RespReady low for 5 cycles in RESP -> P0_Out stays 63 and P0_RespValid stays high; P1_Ready stays 0 throughout.
REQ-037 Reset pulsed in CALC -> next cycle IDLE with all outputs 0 and no RespValid; a fresh 2x2 request then returns 4.
REQ-038 With MULT_ARB_CNT_EN, 300 P0 operations -> P0_GrantCnt=255 and P1_GrantCnt=0.

Source files
------------

// File: rtl/mult_arb_2p.sv
// Two-port arbiter in front of one shared 4x4 unsigned array multiplier (IDLE -> CALC -> RESP).
// Optional per-port grant counters are compiled in when MULT_ARB_CNT_EN is defined.

module arr_multiplier_4b (
    input  logic       Reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P
);
    logic [7:0] acc;

    // Shift-and-add partial products; Reset low forces the product to zero.
    always_comb begin
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            if (B[i]) acc = acc + ({4'b0000, A} << i);
        end
        P = Reset ? acc : 8'd0;
    end
endmodule

module mult_arb_2p #(
    parameter int PRIO_INIT = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       P0_Valid,
    input  logic       P1_Valid,
    output logic       P0_Ready,
    output logic       P1_Ready,
    input  logic [3:0] P0_InA,
    input  logic [3:0] P1_InA,
    input  logic [3:0] P0_InB,
    input  logic [3:0] P1_InB,
    output logic       P0_RespValid,
    output logic       P1_RespValid,
    input  logic       P0_RespReady,
    input  logic       P1_RespReady,
    output logic [7:0] P0_Out,
    output logic [7:0] P1_Out,
    output logic       Busy
`ifdef MULT_ARB_CNT_EN
    ,
    output logic [7:0] P0_GrantCnt,
    output logic [7:0] P1_GrantCnt
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t     state, state_nxt;
    logic       last_srv;
    logic       gnt_sel;
    logic       accept;
    logic       resp_done;
    logic [3:0] op_a_p0, op_b_p0;
    logic       gnt_p0;
    logic [7:0] res_p1;
    logic [7:0] mult_p;

    arr_multiplier_4b u_mult (
        .Reset (1'b1),
        .A     (op_a_p0),
        .B     (op_b_p0),
        .P     (mult_p)
    );

    always_comb begin
        state_nxt = state;
        gnt_sel   = 1'b0;
        accept    = 1'b0;
        resp_done = 1'b0;
        P0_Ready  = 1'b0;
        P1_Ready  = 1'b0;
        case (state)
            IDLE: begin
                // A tie goes to the port that was not served last.
                if (P0_Valid && P1_Valid) gnt_sel = ~last_srv;
                else                      gnt_sel = P1_Valid;
                accept   = (P0_Valid || P1_Valid) && !Reset;
                P0_Ready = accept && !gnt_sel;
                P1_Ready = accept && gnt_sel;
                if (accept) state_nxt = CALC;
            end
            CALC: state_nxt = RESP;
            RESP: begin
                resp_done = gnt_p0 ? P1_RespReady : P0_RespReady;
                if (resp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign P0_RespValid = (state == RESP) && !gnt_p0;
    assign P1_RespValid = (state == RESP) && gnt_p0;
    assign P0_Out       = P0_RespValid ? res_p1 : 8'd0;
    assign P1_Out       = P1_RespValid ? res_p1 : 8'd0;
    assign Busy         = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            last_srv <= (PRIO_INIT != 0) ? 1'b0 : 1'b1;
        end else begin
            state <= state_nxt;
            if (state == RESP && resp_done) last_srv <= gnt_p0;
        end
    end

    // Stage p0: operand capture on acceptance; stage p1: product capture in CALC.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_a_p0 <= '0;
            op_b_p0 <= '0;
            gnt_p0  <= 1'b0;
            res_p1  <= '0;
        end else begin
            if (accept) begin
                op_a_p0 <= gnt_sel ? P1_InA : P0_InA;
                op_b_p0 <= gnt_sel ? P1_InB : P0_InB;
                gnt_p0  <= gnt_sel;
            end
            if (state == CALC) res_p1 <= mult_p;
        end
    end

`ifdef MULT_ARB_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            P0_GrantCnt <= '0;
            P1_GrantCnt <= '0;
        end else begin
            if (P0_Ready && P0_GrantCnt != 8'hFF) P0_GrantCnt <= P0_GrantCnt + 8'd1;
            if (P1_Ready && P1_GrantCnt != 8'hFF) P1_GrantCnt <= P1_GrantCnt + 8'd1;
        end
    end
`endif
endmodule
